sseg_banner_scanner: RTL and testbench

- Consumes the 10 kHz scan clock produced by the clock divider and drives a multiplexed, common-anode seven-segment display.
- Scans one digit per scan tick and shows a sliding window of NUM_DIGITS characters from a loaded message.
- Advances the window by one character every ROT_TICKS scan ticks, wrapping at the message end.
- Everything runs in the 100 MHz domain. The divided clock is treated as data and edge-detected, never used as a clock.

---
 rtl/sseg_banner_scanner_if.sv | 35 +++
 rtl/sseg_banner_scanner.sv | 148 ++++++++++++++
 tb/tb_sseg_banner_scanner.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_banner_scanner_if.sv
// Display-side bundle for sseg_banner_scanner.
//   master: drives div_clk, load, msg, run; receives an, seg, dp, step.
//   slave : the scanner itself.
// Signals:
//   div_clk  divided scan clock, sampled as data in the clk domain
//   load     one-cycle pulse, latches msg into the message buffer
//   msg      5*MSG_LEN bits, char k = msg[5k+4:5k]
//   run      1 = window rotates, 0 = window frozen (scanning continues)
//   an       active-low anode enables, an[0] = rightmost digit
//   seg      active-low segments {g,f,e,d,c,b,a}
//   dp       active-low decimal point, marks the last message character
//   step     one-cycle pulse per window advance
interface sseg_banner_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8
);
  logic                   div_clk;
  logic                   load;
  logic [5*MSG_LEN-1:0]   msg;
  logic                   run;
  logic [NUM_DIGITS-1:0]  an;
  logic [6:0]             seg;
  logic                   dp;
  logic                   step;

  modport master (
    output div_clk, load, msg, run,
    input  an, seg, dp, step
  );

  modport slave (
    input  div_clk, load, msg, run,
    output an, seg, dp, step
  );
endinterface

// File: rtl/sseg_banner_scanner.sv
// Multiplexed common-anode seven-segment banner scanner.
// Scans one digit per rising edge of div_clk (edge-detected in the clk
// domain) and shows a NUM_DIGITS-wide window of a MSG_LEN character
// message; the window slides one character every ROT_TICKS scan ticks.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    sseg_banner_scanner_if.slave (div_clk/load/msg/run in,
//          an/seg/dp/step out)
module sseg_banner_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int ROT_TICKS  = 2500
) (
  input  logic                   clk,
  input  logic                   reset,
  sseg_banner_scanner_if.slave   bus
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MW = (MSG_LEN    > 1) ? $clog2(MSG_LEN)    : 1;
  localparam int RW = (ROT_TICKS  > 1) ? $clog2(ROT_TICKS)  : 1;

  localparam logic [4:0] CODE_BLANK = 5'd16;

  function automatic logic [6:0] seg_decode(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h08;
      5'd11:   s = 7'h03;
      5'd12:   s = 7'h46;
      5'd13:   s = 7'h21;
      5'd14:   s = 7'h06;
      5'd15:   s = 7'h0E;
      5'd17:   s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic                  div_q;
  logic                  scan_tick;
  logic [4:0]            msg_q [MSG_LEN];

  logic [DW-1:0]         dsel_q,   dsel_d;
  logic [MW-1:0]         offset_q, offset_d;
  logic [RW-1:0]         rot_q,    rot_d;
  logic [NUM_DIGITS-1:0] an_q,     an_d;
  logic [6:0]            seg_q,    seg_d;
  logic                  dp_q,     dp_d;
  logic                  step_q,   step_d;

  logic [MW:0]           idx_sum;
  logic [MW:0]           idx_mod;
  logic [MW-1:0]         idx;

  assign scan_tick = bus.div_clk & ~div_q;

  // offset < MSG_LEN and the digit term is <= NUM_DIGITS-1 <= MSG_LEN-1,
  // so a single conditional subtract implements the modulo.
  always_comb begin
    idx_sum = {1'b0, offset_q} + (MW+1)'(NUM_DIGITS - 1) - (MW+1)'(dsel_q);
    idx_mod = (idx_sum >= (MW+1)'(MSG_LEN)) ? idx_sum - (MW+1)'(MSG_LEN) : idx_sum;
    idx     = idx_mod[MW-1:0];
  end

  always_comb begin
    dsel_d   = dsel_q;
    offset_d = offset_q;
    rot_d    = rot_q;
    an_d     = an_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    step_d   = 1'b0;

    if (scan_tick) begin
      an_d  = ~(NUM_DIGITS'(1) << dsel_q);
      seg_d = seg_decode(msg_q[idx]);
      dp_d  = (idx == MW'(MSG_LEN - 1)) ? 1'b0 : 1'b1;
      dsel_d = (dsel_q == DW'(NUM_DIGITS - 1)) ? '0 : dsel_q + DW'(1);

      if (bus.run) begin
        if (rot_q == RW'(ROT_TICKS - 1)) begin
          rot_d    = '0;
          offset_d = (offset_q == MW'(MSG_LEN - 1)) ? '0 : offset_q + MW'(1);
          step_d   = 1'b1;
        end else begin
          rot_d = rot_q + RW'(1);
        end
      end
    end

    // Load overrides a same-cycle rotation wrap, including its step pulse.
    if (bus.load) begin
      offset_d = '0;
      rot_d    = '0;
      step_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= 1'b1;
      dsel_q   <= '0;
      offset_q <= '0;
      rot_q    <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      step_q   <= 1'b0;
    end else begin
      div_q    <= bus.div_clk;
      dsel_q   <= dsel_d;
      offset_q <= offset_d;
      rot_q    <= rot_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      step_q   <= step_d;
    end
  end

  // A tick coinciding with load still reads the old contents, since the
  // display path reads msg_q before this edge updates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < MSG_LEN; k++) msg_q[k] <= CODE_BLANK;
    end else if (bus.load) begin
      for (int unsigned k = 0; k < MSG_LEN; k++) msg_q[k] <= bus.msg[5*k +: 5];
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_sseg_banner_scanner.sv
module tb_sseg_banner_scanner;

  logic clk;
  logic reset;

  sseg_banner_scanner_if #(.NUM_DIGITS(4), .MSG_LEN(6)) bus ();

  sseg_banner_scanner #(.NUM_DIGITS(4), .MSG_LEN(6), .ROT_TICKS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       step;
    int         id;
  } exp_t;

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;
  int   stray  = 0;
  int   tick_no = 0;

  // Reference model state
  logic [4:0] m_buf [6];
  int         m_off, m_rot, m_dsel;

  function automatic logic [6:0] segtab(input logic [4:0] c);
    logic [6:0] t [18];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
          7'h7F, 7'h3F};
    if (c < 5'd18) return t[c];
    return 7'h7F;
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {an,seg,dp,step}=%h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [29:0] pack(input int c0, c1, c2, c3, c4, c5);
    logic [29:0] m;
    m = {5'(c5), 5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 6; k++) m_buf[k] = 5'd16;
    m_off = 0; m_rot = 0; m_dsel = 0;
  endtask

  task automatic model_load(input logic [29:0] m);
    for (int k = 0; k < 6; k++) m_buf[k] = m[5*k +: 5];
    m_off = 0; m_rot = 0;
  endtask

  // One full div_clk period (5 clk low, 5 clk high) with the rising edge
  // optionally coinciding with a load pulse. Expected display is either
  // hand-supplied or taken from the reference model.
  task automatic do_tick(input bit ld, input logic [29:0] m, input bit hand,
                         input logic [3:0] h_an, input logic [6:0] h_seg,
                         input logic h_dp, input logic h_step);
    exp_t e;
    int   idx;
    @(negedge clk); bus.div_clk = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    tick_no++;
    idx = (m_off + 3 - m_dsel) % 6;
    if (hand) begin
      e = '{h_an, h_seg, h_dp, h_step, tick_no};
    end else begin
      e.an   = ~(4'b0001 << m_dsel);
      e.seg  = segtab(m_buf[idx]);
      e.dp   = (idx == 5) ? 1'b0 : 1'b1;
      e.step = bus.run && (m_rot == 2) && !ld;
      e.id   = tick_no;
    end
    sb.push_back(e);
    bus.div_clk = 1'b1;
    bus.load    = ld;
    if (ld) bus.msg = m;
    m_dsel = (m_dsel + 1) % 4;
    if (ld) model_load(m);
    else if (bus.run) begin
      if (m_rot == 2) begin m_rot = 0; m_off = (m_off + 1) % 6; end
      else m_rot++;
    end
    @(negedge clk); bus.load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic mtick();
    do_tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic htick(input logic [3:0] a, input logic [6:0] s, input logic d, input logic st);
    do_tick(1'b0, '0, 1'b1, a, s, d, st);
  endtask

  task automatic load_msg(input logic [29:0] m);
    @(negedge clk); bus.load = 1'b1; bus.msg = m;
    model_load(m);
    @(negedge clk); bus.load = 1'b0;
  endtask

  // Monitor: the DUT's outputs update on the edge that samples a rising
  // div_clk; compare against the scoreboard just after that edge.
  initial begin : monitor
    logic prev, t;
    exp_t e;
    string nm;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      t    = bus.div_clk && !prev && !reset;
      prev = reset ? 1'b1 : bus.div_clk;
      #1;
      if (t) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: DUT tick with no expected entry");
        end else begin
          e = sb.pop_front();
          nm = $sformatf("tick%0d", e.id);
          chk(nm, {bus.an, bus.seg, bus.dp, bus.step}, {e.an, e.seg, e.dp, e.step});
        end
      end else if (bus.step !== 1'b0) begin
        stray++;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    logic [29:0] m123456;
    m123456 = pack(1, 2, 3, 4, 5, 6);
    reset = 1'b1;
    bus.div_clk = 1'b1;
    bus.load = 1'b0;
    bus.msg  = '0;
    bus.run  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("idle_after_reset", {bus.an, bus.seg, bus.dp, bus.step}, {4'hF, 7'h7F, 1'b1, 1'b0});

    // First rising edge: digit 0, blank buffer
    htick(4'b1110, 7'h7F, 1'b1, 1'b0);

    // Frozen window over message 1..6
    load_msg(m123456);
    repeat (3) mtick();
    htick(4'b1110, 7'h19, 1'b1, 1'b0);
    htick(4'b1101, 7'h30, 1'b1, 1'b0);
    htick(4'b1011, 7'h24, 1'b1, 1'b0);
    htick(4'b0111, 7'h79, 1'b1, 1'b0);

    // Rotation: steps every 3rd tick
    bus.run = 1'b1;
    repeat (15) mtick();
    htick(4'b0111, 7'h02, 1'b0, 1'b0);   // offset 5, digit 3 = char 5
    htick(4'b1110, 7'h30, 1'b1, 1'b0);   // digit 0 = char 2
    htick(4'b1101, 7'h24, 1'b1, 1'b1);   // 6th step, offset wraps to 0
    htick(4'b1011, 7'h24, 1'b1, 1'b0);   // offset 0: digit 2 = char 1
    mtick();

    // Load on the third tick of a period: no step, count restarts
    do_tick(1'b1, m123456, 1'b1, 4'b1110, 7'h19, 1'b1, 1'b0);
    mtick();
    mtick();
    htick(4'b0111, 7'h79, 1'b1, 1'b1);

    // Blank / dash / out-of-range codes
    bus.run = 1'b0;
    load_msg(pack(16, 17, 20, 10, 11, 12));
    htick(4'b1110, 7'h08, 1'b1, 1'b0);
    htick(4'b1101, 7'h7F, 1'b1, 1'b0);
    htick(4'b1011, 7'h3F, 1'b1, 1'b0);
    htick(4'b0111, 7'h7F, 1'b1, 1'b0);

    // Reset mid-scan right after an=1011
    load_msg(m123456);
    mtick();
    mtick();
    htick(4'b1011, 7'h24, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midscan_reset", {bus.an, bus.seg, bus.dp, bus.step}, {4'hF, 7'h7F, 1'b1, 1'b0});
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.run = 1'b1;
    mtick();
    mtick();
    htick(4'b1011, 7'h7F, 1'b1, 1'b1);   // full count from 0 after reset
    load_msg(m123456);
    htick(4'b0111, 7'h79, 1'b1, 1'b0);   // offset 0 after reload

    repeat (3) @(negedge clk);
    chk("sb_drained", 13'(sb.size()), 13'd0);
    chk("stray_step", 13'(stray), 13'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
